// File: rtl/bist_controller_if.sv
// Control/datapath bundle for the BIST sequencer; master = controller side.
// sig_cap is present only when BIST_SIG_CAPTURE_EN is defined.
interface bist_controller_if #(
    parameter int CNT_W = 16,
    parameter int SIG_W = 8
);
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] sig_in;
    logic             tpg_en;
    logic             misr_en;
    logic             dp_clr;
    logic [CNT_W-1:0] pat_cnt;
    logic             busy;
    logic             done;
    logic             pass;
`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0] sig_cap;
`endif

    modport master (
        input  start, abort, sig_in,
        output tpg_en, misr_en, dp_clr, pat_cnt, busy, done, pass
`ifdef BIST_SIG_CAPTURE_EN
        , output sig_cap
`endif
    );

    modport slave (
        output start, abort, sig_in,
        input  tpg_en, misr_en, dp_clr, pat_cnt, busy, done, pass
`ifdef BIST_SIG_CAPTURE_EN
        , input sig_cap
`endif
    );
endinterface

// File: rtl/bist_controller.sv
// BIST sequencer: clear TPG/MISR, run PATTERN_COUNT patterns, flush, compare (BIST_SIG_CAPTURE_EN adds sig_cap).
// Latency: start sampled at edge 0 -> done high after edge PATTERN_COUNT+3.
// No backpressure: start is a level request, abort cancels an active run on the next edge.
module bist_controller #(
    parameter int             PATTERN_COUNT = 255,
    parameter int             CNT_W         = 16,
    parameter int             SIG_W         = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    bist_controller_if.master  bus
);
    localparam int               PC_EFF = (PATTERN_COUNT < 1) ? 1 : PATTERN_COUNT;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PC_EFF - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, RUN, FLUSH, COMPARE, DONE
    } state_t;

    state_t state;
    logic   active;

    assign active = (state == INIT) || (state == RUN) ||
                    (state == FLUSH) || (state == COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.tpg_en  <= 1'b0;
            bus.misr_en <= 1'b0;
            bus.dp_clr  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.pass    <= 1'b0;
            bus.pat_cnt <= '0;
`ifdef BIST_SIG_CAPTURE_EN
            bus.sig_cap <= '0;
`endif
        end else begin
            bus.dp_clr <= 1'b0;
            // The pattern applied in an aborted RUN cycle still counts.
            if (state == RUN && bus.pat_cnt != '1)
                bus.pat_cnt <= bus.pat_cnt + 1'b1;

            if (active && bus.abort) begin
                state       <= IDLE;
                bus.tpg_en  <= 1'b0;
                bus.misr_en <= 1'b0;
                bus.busy    <= 1'b0;
                bus.done    <= 1'b0;
                bus.pass    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state       <= INIT;
                        bus.dp_clr  <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.done    <= 1'b0;
                        bus.pass    <= 1'b0;
                        bus.pat_cnt <= '0;
`ifdef BIST_SIG_CAPTURE_EN
                        bus.sig_cap <= '0;
`endif
                    end
                    INIT: begin
                        state       <= RUN;
                        bus.tpg_en  <= 1'b1;
                        bus.misr_en <= 1'b1;
                    end
                    RUN: if (bus.pat_cnt == LAST) begin
                        state      <= FLUSH;
                        bus.tpg_en <= 1'b0;
                    end
                    FLUSH: begin
                        state       <= COMPARE;
                        bus.misr_en <= 1'b0;
                    end
                    COMPARE: begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (bus.sig_in == GOLDEN_SIG);
`ifdef BIST_SIG_CAPTURE_EN
                        bus.sig_cap <= bus.sig_in;
`endif
                    end
                    DONE: if (!bus.start) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: two instances (4 patterns and 1 pattern), scoreboard on run results.
module tb_bist_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bist_controller_if #(.CNT_W(16), .SIG_W(8)) if4 ();
    bist_controller_if #(.CNT_W(16), .SIG_W(8)) if1 ();

    bist_controller #(.PATTERN_COUNT(4), .CNT_W(16), .SIG_W(8), .GOLDEN_SIG(8'h5A))
        dut4 (.clk(clk), .rst(rst), .bus(if4.master));
    bist_controller #(.PATTERN_COUNT(1), .CNT_W(16), .SIG_W(8), .GOLDEN_SIG(8'h5A))
        dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    typedef struct {
        logic       pass;
        logic [7:0] sig;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {dp_clr, tpg_en, misr_en, busy, done, pass}
    function automatic logic [5:0] flags(input int sel);
        if (sel == 1) return {if1.dp_clr, if1.tpg_en, if1.misr_en, if1.busy, if1.done, if1.pass};
        return {if4.dp_clr, if4.tpg_en, if4.misr_en, if4.busy, if4.done, if4.pass};
    endfunction

    function automatic logic [15:0] pat(input int sel);
        return (sel == 1) ? if1.pat_cnt : if4.pat_cnt;
    endfunction

    function automatic logic [7:0] cap(input int sel);
`ifdef BIST_SIG_CAPTURE_EN
        return (sel == 1) ? if1.sig_cap : if4.sig_cap;
`else
        return (sel == 1) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) if1.start = v; else if4.start = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int sel, input logic [7:0] sig, input bit hold, input int pc);
        exp_t e, got;
        int   k = -1;
        int   n_clr = 0, n_tpg = 0, n_misr = 0;
        bit   seen = 0;
        logic [5:0] f;
        e.pass = (sig == 8'h5A);
        e.sig  = sig;
        sbq.push_back(e);
        if (sel == 1) if1.sig_in = sig; else if4.sig_in = sig;
        set_start(sel, 1'b1);
        while (!seen && k < 40) begin
            tick();
            k++;
            if (!hold && k == 0) set_start(sel, 1'b0);
            f = flags(sel);
            n_clr  += int'(f[5]);
            n_tpg  += int'(f[4]);
            n_misr += int'(f[3]);
            if (k == 0) check("init_done_clr", {29'd0, f[2:0]}, 32'h4);
            if (k == pc + 1) check("pat_cnt_flush", {16'd0, pat(sel)}, pc);
            if (f[1]) seen = 1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", k, pc + 3);
        check("dp_clr_cycles", n_clr, 1);
        check("tpg_en_cycles", n_tpg, pc);
        check("misr_en_cycles", n_misr, pc + 1);
        check("busy_in_done", {31'd0, f[2]}, 32'd0);
        got = sbq.pop_front();
        check("pass", {31'd0, f[0]}, {31'd0, got.pass});
`ifdef BIST_SIG_CAPTURE_EN
        check("sig_cap", {24'd0, cap(sel)}, {24'd0, got.sig});
`endif
    endtask

    initial begin
        int act;
        if4.start = 0; if4.abort = 0; if4.sig_in = 8'h00;
        if1.start = 0; if1.abort = 0; if1.sig_in = 8'h00;
        #2;
        check("reset_flags4", {26'd0, flags(0)}, 0);
        check("reset_pat4", {16'd0, pat(0)}, 0);
        check("reset_flags1", {26'd0, flags(1)}, 0);
        check("reset_cap4", {24'd0, cap(0)}, 0);
        rst = 0;
        repeat (2) tick();

        run(0, 8'h5A, 0, 4);
        repeat (2) tick();
        check("idle_keeps_result", {26'd0, flags(0)}, 32'h3);

        run(0, 8'h5B, 0, 4);
        repeat (2) tick();

        // Abort in the second RUN cycle.
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        tick();
        tick();
        if4.abort = 1;
        tick();
        if4.abort = 0;
        check("abort_flags", {26'd0, flags(0)}, 0);
        check("abort_pat_cnt", {16'd0, pat(0)}, 2);
        repeat (2) tick();
        check("abort_idle_stays", {26'd0, flags(0)}, 0);

        // Asynchronous reset in the middle of RUN.
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        repeat (2) tick();
        check("run_before_rst", {26'd0, flags(0)}, 32'h1C);
        #2 rst = 1;
        #1;
        check("rst_async_flags", {26'd0, flags(0)}, 0);
        check("rst_async_pat", {16'd0, pat(0)}, 0);
        #2 rst = 0;
        act = 0;
        repeat (5) begin
            tick();
            act += int'(flags(0) != 6'd0);
        end
        check("post_rst_quiet", act, 0);

        // start held through DONE, then a fresh request.
        run(0, 8'h5A, 1, 4);
        act = 0;
        repeat (4) begin
            tick();
            act += int'(flags(0) != 6'h03);
        end
        check("hold_stays_done", act, 0);
        set_start(0, 1'b0);
        tick();
        set_start(0, 1'b1);
        tick();
        check("restart_init", {26'd0, flags(0)}, 32'h24);
        set_start(0, 1'b0);
        if4.abort = 1;
        tick();
        if4.abort = 0;
        check("restart_abort", {26'd0, flags(0)}, 0);

        run(1, 8'h5A, 0, 1);
        check("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Sequencer for the 8-bit BIST datapath: drives the pattern-generator LFSR, the circuit under test and the signature-compressing MISR through one self-test run. It clears both registers, runs a fixed number of pattern cycles, flushes the last response into the MISR, then compares the final signature with a golden value. It sits between the system test-control logic (start/abort in, done/pass out) and the TPG/MISR datapath wrappers.

Parameters:
PATTERN_COUNT, 255, number of RUN cycles (patterns applied); legal range 1..2^CNT_W-1, 0 treated as 1
CNT_W, 16, width of the pattern counter
SIG_W, 8, signature width (matches MISR width)
GOLDEN_SIG, 8'h00, expected fault-free signature; overridden per CUT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level request to run a test; sampled in IDLE and DONE
abort  input  1  cancels a run in progress
sig_in  input  SIG_W  current MISR contents (q of MISR)
tpg_en  output  1  pattern-generator advance enable
misr_en  output  1  MISR capture enable
dp_clr  output  1  synchronous clear/seed request to TPG and MISR
pat_cnt  output  CNT_W  patterns applied in the current run
busy  output  1  high from INIT through COMPARE
done  output  1  run completed, result valid (sticky)
pass  output  1  signature matched GOLDEN_SIG (valid when done=1)

Behaviour:
- Reset (async, rst=1): state=IDLE; tpg_en=misr_en=dp_clr=busy=done=pass=0; pat_cnt=0. Reset mid-run aborts immediately; no partial result.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- IDLE: start=1 -> INIT. done/pass keep previous result.
- INIT (1 cycle): dp_clr=1, busy=1; done, pass and pat_cnt cleared to 0. -> RUN.
- RUN: tpg_en=misr_en=1, busy=1; pat_cnt increments each cycle. Exit to FLUSH on the cycle pat_cnt==PATTERN_COUNT-1 (RUN lasts exactly PATTERN_COUNT cycles; pat_cnt reads PATTERN_COUNT in FLUSH).
- FLUSH (1 cycle): tpg_en=0, misr_en=1, so the MISR absorbs the CUT response to the last pattern. -> COMPARE.
- COMPARE (1 cycle): misr_en=0; pass <= (sig_in==GOLDEN_SIG); done <= 1. -> DONE.
- DONE: busy=0, done=1 held. start=0 -> IDLE; start held high stays in DONE (no auto-restart). A new run needs start low then high.
- Latency: with start sampled high at edge 0, done is high after edge PATTERN_COUNT+3.
- abort=1 in INIT/RUN/FLUSH/COMPARE: -> IDLE next edge; enables drop; done=0, pass=0; pat_cnt holds its value for debug. abort is ignored in IDLE and DONE. If abort and the COMPARE transition coincide, abort wins.
- start while busy is ignored.
- pat_cnt saturates; it does not wrap within a legal run.

Optional Feature:
BIST_SIG_CAPTURE_EN - when defined: extra output sig_cap [SIG_W-1:0], loaded with sig_in in COMPARE, cleared by rst and in INIT, held otherwise, for diagnosis of failing signatures. When undefined: port and register absent; pass/done behaviour identical.

Test Plan:
- PATTERN_COUNT=4, GOLDEN_SIG=8'h5A, start pulse, sig_in=8'h5A at COMPARE -> dp_clr 1 cycle, tpg_en 4 cycles, misr_en 5 cycles, done=1 and pass=1 after edge 7, busy low in DONE.
- Same, sig_in=8'h5B at COMPARE -> done=1, pass=0; with BIST_SIG_CAPTURE_EN, sig_cap=8'h5B.
- abort=1 on the 2nd RUN cycle -> IDLE next edge, tpg_en=misr_en=0, done=0, pass=0, pat_cnt=2.
- rst asserted mid-RUN, not aligned to clk -> all outputs 0 immediately; after release, IDLE with start=0 produces no activity.
- start held high through DONE -> stays DONE, no second INIT; drop start for 1 cycle, raise again -> new INIT clears done/pass.
- PATTERN_COUNT=1 -> exactly one tpg_en cycle, done after edge 4.
